sparse_chunk_writer: RTL
========================

SPARSE_CHUNK_WRITER -- requirements
Module: sparse_chunk_writer

Interface
REQ-001 SHALL have parameter WR_DAT_CYC_NUM, default `MEM_SIZE/`BUS_SIZE, meaning beats per full chunk.
REQ-002 SHALL have parameter CNT_W, default $clog2(WR_DAT_CYC_NUM), meaning write-count width.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, named as follows:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  asynchronous active-high reset.
REQ-004 SHALL have the following data ports:
- dense_valid_i  in  1  upstream beat valid.
- dense_ready_o  out  1  beat accepted when valid&ready.
- dense_data_i  in  `BUS_SIZE x 8  dense bytes, lane 0 = lowest channel.
- dense_last_i  in  1  last beat of chunk (early end).
- bank_release_i  in  2  per-bank pulse from consumer: bank fully read.
- sparsemap_o  out  `BUS_SIZE  bit i = (dense byte i != 0).
- nonzero_data_o  out  `BUS_SIZE x 8  compacted nonzero bytes.
- wr_valid_o  out  1  write strobe to compute-unit buffer.
- wr_count_o  out  CNT_W  beat index within chunk.
- wr_sel_o  out  1  target bank of the current write.
- chunk_done_o  out  1  one-cycle pulse with final beat of chunk.
- chunk_nnz_o  out  $clog2(`MEM_SIZE)+1  nonzero count of completed chunk, valid with chunk_done_o.

Function
REQ-005 Accept: a beat SHALL be accepted iff dense_valid_i & dense_ready_o.
REQ-006 dense_ready_o SHALL be combinational = ~bank_full[cur_bank].
REQ-007 Output pipeline: an accepted beat at edge N SHALL appear on all outputs for exactly the cycle after edge N, with wr_valid_o=1; with no accept, wr_valid_o SHALL be 0 and the data outputs SHALL hold their previous values.
REQ-008 Compaction: nonzero_data_o lane k SHALL hold the k-th nonzero input byte in ascending lane order, for k < popcount; lanes >= popcount SHALL be 0.
REQ-009 Count: wr_count_o SHALL equal the beat index within the chunk (0, 1, ...); the internal counter SHALL reset to 0 after the last beat.
REQ-010 Last beat: a beat SHALL be last when dense_last_i=1 or the beat index = WR_DAT_CYC_NUM-1.
REQ-011 Bank ownership: each bank SHALL be in state FREE or FULL, tracked by bank_full[1:0].
REQ-012 Last-beat accept: on accept of the last beat, the writer SHALL set bank_full[cur_bank], toggle cur_bank, and zero the counter.
REQ-013 Completion: chunk_done_o SHALL pulse together with the last beat's wr_valid_o, and chunk_nnz_o SHALL be the sum of popcounts of all beats of that chunk.
REQ-014 The nonzero accumulator SHALL be wide enough for WR_DAT_CYC_NUM*`BUS_SIZE without wrap.
REQ-015 Release: bank_release_i[b] SHALL clear bank_full[b].
REQ-016 Release of a FREE bank SHALL be ignored.
REQ-017 If set and release of the same bank occur in the same cycle, set SHALL win.
REQ-018 Release of the bank being waited on SHALL make dense_ready_o 1 in the next cycle.
REQ-019 Stall: when both banks are FULL, dense_ready_o SHALL be 0; the counter and cur_bank SHALL hold.
REQ-020 An all-zero beat SHALL still be written, with sparsemap_o=0 and nonzero_data_o=0.
REQ-021 A one-beat chunk (dense_last_i on beat 0) SHALL be legal: wr_count_o=0 with chunk_done_o=1.

Reset
REQ-022 On rst_i=1, asynchronously: wr_valid_o=0, chunk_done_o=0, wr_count_o=0, wr_sel_o=0, sparsemap_o=0, nonzero_data_o=0, chunk_nnz_o=0, bank_full=2'b00, cur_bank=0, counter=0.
REQ-023 Reset mid-chunk SHALL discard the partial chunk; the first beat after reset SHALL be written with wr_count_o=0 and wr_sel_o=0.
REQ-024 dense_ready_o SHALL be 1 during and after reset.

Verification
REQ-025 Compaction: with `BUS_SIZE=8, beat bytes {0,5,0,0,7,0,0,9} -> next cycle sparsemap_o=8'b1001_0010, nonzero_data_o lanes 0..2 = 5,7,9, other lanes 0, wr_valid_o=1.
REQ-026 Full chunk: WR_DAT_CYC_NUM back-to-back beats of all-nonzero bytes -> wr_count_o 0..WR_DAT_CYC_NUM-1, wr_sel_o=0 throughout, chunk_done_o on the final beat, chunk_nnz_o=`MEM_SIZE; the next beat is written with wr_sel_o=1 and wr_count_o=0.
REQ-027 Backpressure: write two chunks with no release -> dense_ready_o=0, outputs idle; pulse bank_release_i=2'b01 -> ready=1 next cycle, next write has wr_sel_o=0.
REQ-028 Early end: dense_last_i on beat 2 -> chunk_done_o with wr_count_o=2; the following beat has wr_count_o=0 on the other bank.
REQ-029 Set/release collision: release bank 0 in the same cycle its last beat is accepted -> bank 0 stays FULL; a release on a FREE bank changes nothing.
REQ-030 Reset during beat 3 of a chunk -> all outputs 0 at once; the next accepted beat has wr_count_o=0, wr_sel_o=0, and chunk_nnz_o counts only post-reset beats.

Source files
------------

// File: rtl/sparse_chunk_writer_if.sv
// Dense-beat input and compacted-write output bundle of the sparse chunk writer.
`ifndef BUS_SIZE
`define BUS_SIZE 8
`endif
`ifndef MEM_SIZE
`define MEM_SIZE 32
`endif

interface sparse_chunk_writer_if #(
    parameter int CNT_W = $clog2(`MEM_SIZE / `BUS_SIZE)
);
    logic                        dense_valid_i;
    logic                        dense_ready_o;
    logic [`BUS_SIZE-1:0][7:0]   dense_data_i;
    logic                        dense_last_i;
    logic [1:0]                  bank_release_i;
    logic [`BUS_SIZE-1:0]        sparsemap_o;
    logic [`BUS_SIZE-1:0][7:0]   nonzero_data_o;
    logic                        wr_valid_o;
    logic [CNT_W-1:0]            wr_count_o;
    logic                        wr_sel_o;
    logic                        chunk_done_o;
    logic [$clog2(`MEM_SIZE):0]  chunk_nnz_o;

    modport slave (
        input  dense_valid_i, dense_data_i, dense_last_i, bank_release_i,
        output dense_ready_o, sparsemap_o, nonzero_data_o, wr_valid_o,
               wr_count_o, wr_sel_o, chunk_done_o, chunk_nnz_o
    );

    modport master (
        output dense_valid_i, dense_data_i, dense_last_i, bank_release_i,
        input  dense_ready_o, sparsemap_o, nonzero_data_o, wr_valid_o,
               wr_count_o, wr_sel_o, chunk_done_o, chunk_nnz_o
    );
endinterface

// File: rtl/sparse_chunk_writer.sv
// Compacts nonzero bytes of each dense beat into a ping-pong bank pair; outputs one cycle after accept.
// Ready drops while the current bank is still owned by the consumer.
`ifndef BUS_SIZE
`define BUS_SIZE 8
`endif
`ifndef MEM_SIZE
`define MEM_SIZE 32
`endif

module sparse_chunk_writer #(
    parameter int WR_DAT_CYC_NUM = `MEM_SIZE / `BUS_SIZE,
    parameter int CNT_W          = $clog2(WR_DAT_CYC_NUM)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    sparse_chunk_writer_if.slave bus
);
    localparam int BUS   = `BUS_SIZE;
    localparam int POP_W = $clog2(BUS) + 1;
    localparam int NNZ_W = $clog2(`MEM_SIZE) + 1;
    localparam int ACC_W = $clog2(WR_DAT_CYC_NUM * BUS) + 1;

    logic [1:0]            r_bank_full;
    logic                  r_cur_bank;
    logic [CNT_W-1:0]      r_cnt;
    logic [ACC_W-1:0]      r_acc;

    logic                  r_wr_vld;
    logic                  r_done;
    logic [CNT_W-1:0]      r_wr_cnt;
    logic                  r_wr_sel;
    logic [BUS-1:0]        r_map;
    logic [BUS-1:0][7:0]   r_nz;
    logic [NNZ_W-1:0]      r_nnz;

    logic                  w_rdy;
    logic                  w_acc;
    logic                  w_last;
    logic [1:0]            w_set;
    logic [BUS-1:0]        w_map;
    logic [BUS-1:0][7:0]   w_nz;
    logic [POP_W-1:0]      w_pop;
    logic [ACC_W-1:0]      w_acc_nxt;

    assign w_rdy  = ~r_bank_full[r_cur_bank];
    assign w_acc  = bus.dense_valid_i & w_rdy;
    assign w_last = bus.dense_last_i | (r_cnt == CNT_W'(WR_DAT_CYC_NUM - 1));
    assign w_set  = (w_acc & w_last) ? (2'b01 << r_cur_bank) : 2'b00;
    assign w_acc_nxt = r_acc + ACC_W'(w_pop);

    // Lane k of the compacted beat takes the k-th nonzero byte scanning up from lane 0.
    always_comb begin
        int k;
        k     = 0;
        w_map = '0;
        w_nz  = '0;
        for (int i = 0; i < BUS; i++) begin
            w_map[i] = |bus.dense_data_i[i];
            if (w_map[i]) begin
                w_nz[k] = bus.dense_data_i[i];
                k       = k + 1;
            end
        end
        w_pop = POP_W'(k);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bank_full <= 2'b00;
            r_cur_bank  <= 1'b0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_wr_vld    <= 1'b0;
            r_done      <= 1'b0;
            r_wr_cnt    <= '0;
            r_wr_sel    <= 1'b0;
            r_map       <= '0;
            r_nz        <= '0;
            r_nnz       <= '0;
        end else begin
            r_wr_vld <= w_acc;
            r_done   <= w_acc & w_last;
            // A set in the same cycle as a release of that bank must leave it FULL.
            r_bank_full <= (r_bank_full & ~bus.bank_release_i) | w_set;
            if (w_acc) begin
                r_map    <= w_map;
                r_nz     <= w_nz;
                r_wr_cnt <= r_cnt;
                r_wr_sel <= r_cur_bank;
                if (w_last) begin
                    r_cnt      <= '0;
                    r_cur_bank <= ~r_cur_bank;
                    r_acc      <= '0;
                    r_nnz      <= NNZ_W'(w_acc_nxt);
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    r_acc <= w_acc_nxt;
                end
            end
        end
    end

    assign bus.dense_ready_o  = w_rdy;
    assign bus.sparsemap_o    = r_map;
    assign bus.nonzero_data_o = r_nz;
    assign bus.wr_valid_o     = r_wr_vld;
    assign bus.wr_count_o     = r_wr_cnt;
    assign bus.wr_sel_o       = r_wr_sel;
    assign bus.chunk_done_o   = r_done;
    assign bus.chunk_nnz_o    = r_nnz;
endmodule
